ones_counter_seq: RTL and testbench

- Sequential, parametrised population-count (ones counter) unit.
- Generalises the 3-input, 2-bit ones counter to WIDTH-bit operands, processed CHUNK bits per clock.
- Adds a start/done handshake, an accumulate mode across operands, a saturating result with a sticky flag, and a synchronous clear/abort.
- Used wherever a multi-cycle, area-cheap bit count of a wide word is needed.

---
 rtl/ones_counter_seq.sv | 166 ++++++++++++++++
 tb/tb_ones_counter_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ones_counter_seq.sv
// Multi-cycle population counter: counts CHUNK bits of a WIDTH-bit operand per clock,
// with optional accumulation into a saturating result and a sticky saturation flag.
module ones_counter_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic             accumulate,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] count,
    output logic             sat
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int PS_W  = $clog2(WIDTH + 1);
    localparam int CYC_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [PS_W-1:0] chunk_pop(input logic [CHUNK-1:0] bits);
        logic [PS_W-1:0] acc;
        acc = {PS_W{1'b0}};
        for (int i = 0; i < CHUNK; i++) begin
            acc = acc + PS_W'(bits[i]);
        end
        return acc;
    endfunction

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] shift_r;
    logic [PS_W-1:0]  partial_r;
    logic [CYC_W-1:0] cyc_r;
    logic             mode_r;
    logic             busy_r;
    logic             done_r;
    logic [ACC_W-1:0] count_r;
    logic             sat_r;

    logic             accept_s;
    logic             last_step_s;
    logic [PS_W-1:0]  chunk_cnt_s;
    logic [PS_W-1:0]  partial_sum_s;
    logic [ACC_W:0]   part_ext_s;
    logic [ACC_W:0]   acc_sum_s;
    logic [ACC_W-1:0] result_s;
    logic             result_sat_s;

    // Next-state decode and result arithmetic for the final counting step.
    always_comb begin
        accept_s      = (state_r == IDLE) && start && !clear;
        last_step_s   = (cyc_r == CYC_W'(STEPS - 1));
        chunk_cnt_s   = chunk_pop(shift_r[CHUNK-1:0]);
        // The final chunk is folded in combinationally so the result lands with done.
        partial_sum_s = partial_r + chunk_cnt_s;
        part_ext_s    = {{(ACC_W + 1 - PS_W){1'b0}}, partial_sum_s};
        acc_sum_s     = {1'b0, count_r} + part_ext_s;
        result_s      = count_r;
        result_sat_s  = sat_r;
        state_nx_s    = state_r;

        if (!mode_r) begin
            result_s     = part_ext_s[ACC_W-1:0];
            result_sat_s = sat_r;
        end else if (acc_sum_s[ACC_W]) begin
            result_s     = {ACC_W{1'b1}};
            result_sat_s = 1'b1;
        end else begin
            result_s     = acc_sum_s[ACC_W-1:0];
            result_sat_s = sat_r;
        end

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = COUNT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            COUNT: begin
                if (clear) begin
                    state_nx_s = IDLE;
                end else if (last_step_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = COUNT;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand shift register, partial sum, step counter and captured mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r   <= {WIDTH{1'b0}};
            partial_r <= {PS_W{1'b0}};
            cyc_r     <= {CYC_W{1'b0}};
            mode_r    <= 1'b0;
        end else if (accept_s) begin
            shift_r   <= data;
            partial_r <= {PS_W{1'b0}};
            cyc_r     <= {CYC_W{1'b0}};
            mode_r    <= accumulate;
        end else if (state_r == COUNT) begin
            shift_r   <= shift_r >> CHUNK;
            partial_r <= partial_sum_s;
            cyc_r     <= cyc_r + CYC_W'(1);
        end else begin
            shift_r   <= shift_r;
            partial_r <= partial_r;
            cyc_r     <= cyc_r;
            mode_r    <= mode_r;
        end
    end

    // Registered outputs; clear zeroes the result and suppresses a pending done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            count_r <= {ACC_W{1'b0}};
            sat_r   <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == COUNT);
            if (clear) begin
                done_r  <= 1'b0;
                count_r <= {ACC_W{1'b0}};
                sat_r   <= 1'b0;
            end else if ((state_r == COUNT) && last_step_s) begin
                done_r  <= 1'b1;
                count_r <= result_s;
                sat_r   <= result_sat_s;
            end else begin
                done_r  <= 1'b0;
            end
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign count = count_r;
    assign sat   = sat_r;

endmodule

// File: tb/tb_ones_counter_seq.sv
// Directed self-checking bench for ones_counter_seq: default 16/4/8 config plus the
// exhaustive 3-bit configs with CHUNK=1 and CHUNK=3.
module tb_ones_counter_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] data;
    logic        accumulate;
    logic        clear;
    logic        busy;
    logic        done;
    logic [7:0]  count;
    logic        sat;

    logic        start_s;
    logic [2:0]  data_s;
    logic        acc_s;
    logic        clr_s;
    logic        busy1, done1, sat1;
    logic [1:0]  count1;
    logic        busy3, done3, sat3;
    logic [1:0]  count3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ones_counter_seq #(.WIDTH(16), .CHUNK(4), .ACC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data), .accumulate(accumulate),
        .clear(clear), .busy(busy), .done(done), .count(count), .sat(sat)
    );

    ones_counter_seq #(.WIDTH(3), .CHUNK(1), .ACC_W(2)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .start(start_s), .data(data_s), .accumulate(acc_s),
        .clear(clr_s), .busy(busy1), .done(done1), .count(count1), .sat(sat1)
    );

    ones_counter_seq #(.WIDTH(3), .CHUNK(3), .ACC_W(2)) dut_c3 (
        .clk(clk), .rst_n(rst_n), .start(start_s), .data(data_s), .accumulate(acc_s),
        .clear(clr_s), .busy(busy3), .done(done3), .count(count3), .sat(sat3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; report the cycle (1 = cycle after acceptance) where done shows.
    task automatic run_op(input logic [15:0] d, input logic acc, input logic hold,
                          output int done_at, output int busy_cyc);
        data       = d;
        accumulate = acc;
        start      = 1'b1;
        tick();
        if (hold) begin
            data       = ~d;
            accumulate = ~acc;
        end else begin
            start = 1'b0;
        end
        done_at  = 0;
        busy_cyc = 0;
        for (int i = 1; i <= 12; i++) begin
            if (done === 1'b1) begin
                done_at = i;
                break;
            end
            if (busy === 1'b1) busy_cyc++;
            tick();
        end
        start = 1'b0;
        tick();
    endtask

    task automatic op_check(input string tag, input logic [15:0] d, input logic acc,
                            input int exp_cnt, input int exp_sat);
        int da, bc;
        run_op(d, acc, 1'b0, da, bc);
        chk({tag, "_lat"}, da, 5);
        chk({tag, "_cnt"}, count, exp_cnt);
        chk({tag, "_sat"}, sat, exp_sat);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    localparam logic [1:0] POP3 [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    initial begin
        int da, bc, seen;
        rst_n = 1'b0; start = 1'b0; data = 16'h0000; accumulate = 1'b0; clear = 1'b0;
        start_s = 1'b0; data_s = 3'd0; acc_s = 1'b0; clr_s = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_sat", sat, 0);

        // Basic count with start held and data wiggled while busy.
        run_op(16'hF0F1, 1'b0, 1'b1, da, bc);
        chk("basic_lat", da, 5);
        chk("basic_busy", bc, 4);
        chk("basic_cnt", count, 9);
        chk("basic_done_drop", done, 0);
        chk("basic_idle", busy, 0);

        op_check("acc_ffff", 16'hFFFF, 1'b1, 25, 0);
        op_check("acc_zero", 16'h0000, 1'b1, 25, 0);
        op_check("rep_0003", 16'h0003, 1'b0, 2, 0);

        // Saturation across sixteen full-word accumulations.
        pulse_clear();
        chk("clr_cnt", count, 0);
        for (int n = 1; n <= 16; n++) begin
            run_op(16'hFFFF, 1'b1, 1'b0, da, bc);
            if (n == 15) begin
                chk("sat15_cnt", count, 240);
                chk("sat15_sat", sat, 0);
            end
        end
        chk("sat16_cnt", count, 255);
        chk("sat16_sat", sat, 1);
        op_check("sat_rep", 16'h0001, 1'b0, 1, 1);
        pulse_clear();
        chk("satclr_cnt", count, 0);
        chk("satclr_sat", sat, 0);

        // Abort mid-count.
        op_check("pre_abort", 16'h0003, 1'b0, 2, 0);
        data = 16'hFFFF; accumulate = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_cnt", count, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        chk("abort_quiet", seen, 0);

        // clear and start together in IDLE: start dropped.
        clear = 1'b1; start = 1'b1; data = 16'hFFFF;
        tick();
        clear = 1'b0; start = 1'b0;
        chk("clrstart_busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        chk("clrstart_quiet", seen, 0);
        chk("clrstart_cnt", count, 0);

        // Rebuild sat=1, then reset asynchronously in the middle of COUNT.
        for (int n = 0; n < 16; n++) run_op(16'hFFFF, 1'b1, 1'b0, da, bc);
        chk("pre_rst_sat", sat, 1);
        data = 16'hFFFF; accumulate = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_cnt", count, 0);
        chk("arst_sat", sat, 0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        chk("arst_quiet", seen, 0);

        // Exhaustive 3-bit operands on both small configurations.
        for (int v = 0; v < 8; v++) begin
            int d1, d3;
            data_s  = v[2:0];
            start_s = 1'b1;
            tick();
            start_s = 1'b0;
            d1 = 0;
            d3 = 0;
            for (int i = 1; i <= 8; i++) begin
                if (done1 === 1'b1 && d1 == 0) d1 = i;
                if (done3 === 1'b1 && d3 == 0) d3 = i;
                tick();
            end
            chk($sformatf("c1_lat_%0d", v), d1, 4);
            chk($sformatf("c3_lat_%0d", v), d3, 2);
            chk($sformatf("c1_cnt_%0d", v), count1, POP3[v]);
            chk($sformatf("c3_cnt_%0d", v), count3, POP3[v]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
